// File: rtl/nrisc_pkg.sv
// Shared widths and FIFO geometry for the ULA write-back stage.
package nrisc_pkg;

  localparam int TAM_DEF    = 16;
  localparam int RA_W_DEF   = 4;
  localparam int FLAG_W     = 3;
  localparam int FIFO_DEPTH = 2;
  localparam int PTR_W      = 1;
  localparam int CNT_W      = 2;

  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_EMPTY = '0;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/nrisc_wb_fifo.sv
// Two-entry write FIFO between the ULA and the register file.
// Storage is not reset; only pointers and count are.
module nrisc_wb_fifo
  import nrisc_pkg::*;
#(
  parameter int W = TAM_DEF + RA_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  logic [W-1:0]     mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  fifo_op_e         op;

  assign op    = fifo_op_e'({push, pop});
  assign full  = (count == CNT_FULL);
  assign empty = (count == CNT_EMPTY);
  assign dout  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case (op)
        OP_PUSH: count <= count + 1'b1;
        OP_POP:  count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/nrisc_ula_wb.sv
// ULA write-back stage: buffers register writes, latches status
// flags and counts cycles the ULA was held off.
module nrisc_ula_wb
  import nrisc_pkg::*;
#(
  parameter int TAM  = TAM_DEF,
  parameter int RA_W = RA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TAM-1:0]    ULA_OUT,
  input  logic [FLAG_W-1:0] ULA_flags,
  input  logic              in_valid,
  input  logic [RA_W-1:0]   in_rd,
  input  logic              in_rf_we,
  input  logic              in_flag_we,
  output logic              in_ready,
  output logic              wb_valid,
  output logic [TAM-1:0]    wb_data,
  output logic [RA_W-1:0]   wb_rd,
  input  logic              wb_ready,
  output logic [FLAG_W-1:0] flags_reg,
  output logic [7:0]        stall_cnt
);

  logic                accept;
  logic                push;
  logic                pop;
  logic                full;
  logic                empty;
  logic [TAM+RA_W-1:0] head;

  // in_ready depends only on registered occupancy, never on wb_ready
  assign in_ready = ~full;
  assign wb_valid = ~empty;
  assign accept   = in_valid & in_ready;
  assign push     = accept & in_rf_we;
  assign pop      = wb_valid & wb_ready;
  assign wb_data  = head[TAM+RA_W-1:RA_W];
  assign wb_rd    = head[RA_W-1:0];

  nrisc_wb_fifo #(
    .W(TAM + RA_W)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .din  ({ULA_OUT, in_rd}),
    .dout (head),
    .full (full),
    .empty(empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flags_reg <= '0;
    end else if (accept && in_flag_we) begin
      flags_reg <= ULA_flags;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (in_valid && !in_ready && stall_cnt != 8'hFF) begin
      stall_cnt <= stall_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_nrisc_ula_wb.sv
// Directed bench for the ULA write-back stage.
module tb_nrisc_ula_wb;

  logic        clk;
  logic        rst;
  logic [15:0] ULA_OUT;
  logic [2:0]  ULA_flags;
  logic        in_valid;
  logic [3:0]  in_rd;
  logic        in_rf_we;
  logic        in_flag_we;
  logic        in_ready;
  logic        wb_valid;
  logic [15:0] wb_data;
  logic [3:0]  wb_rd;
  logic        wb_ready;
  logic [2:0]  flags_reg;
  logic [7:0]  stall_cnt;

  int passed;
  int total;

  nrisc_ula_wb dut (
    .clk       (clk),
    .rst       (rst),
    .ULA_OUT   (ULA_OUT),
    .ULA_flags (ULA_flags),
    .in_valid  (in_valid),
    .in_rd     (in_rd),
    .in_rf_we  (in_rf_we),
    .in_flag_we(in_flag_we),
    .in_ready  (in_ready),
    .wb_valid  (wb_valid),
    .wb_data   (wb_data),
    .wb_rd     (wb_rd),
    .wb_ready  (wb_ready),
    .flags_reg (flags_reg),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] d,
                       input logic [3:0] rd, input logic rf,
                       input logic [2:0] f, input logic fw);
    in_valid   = v;
    ULA_OUT    = d;
    in_rd      = rd;
    in_rf_we   = rf;
    ULA_flags  = f;
    in_flag_we = fw;
  endtask

  task automatic test_reset();
    rst      = 1'b0;
    wb_ready = 1'b0;
    drive(1'b1, 16'h7777, 4'd9, 1'b1, 3'b111, 1'b1);
    step();
    step();
    total++;
    if (in_ready !== 1'b1)
      $display("FAIL reset_in_ready got %b want 1", in_ready);
    else passed++;
    total++;
    if (wb_valid !== 1'b0 || wb_data !== 16'h0 || wb_rd !== 4'h0)
      $display("FAIL reset_wb got v=%b d=%h rd=%h want 0/0/0",
               wb_valid, wb_data, wb_rd);
    else passed++;
    total++;
    if (flags_reg !== 3'b000 || stall_cnt !== 8'd0)
      $display("FAIL reset_regs got f=%b s=%0d want 000/0",
               flags_reg, stall_cnt);
    else passed++;
    drive(1'b0, 16'h0, 4'd0, 1'b0, 3'b000, 1'b0);
    rst = 1'b1;
    step();
    step();
    total++;
    if (wb_valid !== 1'b0)
      $display("FAIL reset_release_write got %b want 0", wb_valid);
    else passed++;
  endtask

  task automatic test_single_write();
    wb_ready = 1'b1;
    drive(1'b1, 16'h1234, 4'd3, 1'b1, 3'b000, 1'b0);
    step();
    drive(1'b0, 16'h0, 4'd0, 1'b0, 3'b000, 1'b0);
    total++;
    if (wb_valid !== 1'b1 || wb_data !== 16'h1234 || wb_rd !== 4'd3)
      $display("FAIL single_out got v=%b d=%h rd=%0d want 1/1234/3",
               wb_valid, wb_data, wb_rd);
    else passed++;
    step();
    total++;
    if (wb_valid !== 1'b0)
      $display("FAIL single_drain got %b want 0", wb_valid);
    else passed++;
  endtask

  task automatic test_backpressure();
    wb_ready = 1'b0;
    drive(1'b1, 16'h000A, 4'd1, 1'b1, 3'b000, 1'b0);
    step();
    total++;
    if (in_ready !== 1'b1 || wb_data !== 16'h000A)
      $display("FAIL bp_first got rdy=%b d=%h want 1/000a",
               in_ready, wb_data);
    else passed++;
    drive(1'b1, 16'h000B, 4'd2, 1'b1, 3'b000, 1'b0);
    step();
    total++;
    if (in_ready !== 1'b0 || stall_cnt !== 8'd0)
      $display("FAIL bp_full got rdy=%b s=%0d want 0/0",
               in_ready, stall_cnt);
    else passed++;
    drive(1'b1, 16'h000C, 4'd4, 1'b1, 3'b000, 1'b0);
    step();
    total++;
    if (stall_cnt !== 8'd1)
      $display("FAIL bp_stall1 got %0d want 1", stall_cnt);
    else passed++;
    step();
    total++;
    if (stall_cnt !== 8'd2 || wb_data !== 16'h000A || wb_rd !== 4'd1)
      $display("FAIL bp_stall2 got s=%0d d=%h rd=%0d want 2/000a/1",
               stall_cnt, wb_data, wb_rd);
    else passed++;
    wb_ready = 1'b1;
    step();
    total++;
    if (stall_cnt !== 8'd3 || in_ready !== 1'b1 ||
        wb_data !== 16'h000B || wb_rd !== 4'd2)
      $display("FAIL bp_pop_a got s=%0d rdy=%b d=%h want 3/1/000b",
               stall_cnt, in_ready, wb_data);
    else passed++;
    step();
    drive(1'b0, 16'h0, 4'd0, 1'b0, 3'b000, 1'b0);
    total++;
    if (wb_valid !== 1'b1 || wb_data !== 16'h000C || wb_rd !== 4'd4)
      $display("FAIL bp_accept_c got v=%b d=%h rd=%0d want 1/000c/4",
               wb_valid, wb_data, wb_rd);
    else passed++;
    step();
    total++;
    if (wb_valid !== 1'b0 || stall_cnt !== 8'd3)
      $display("FAIL bp_drain got v=%b s=%0d want 0/3",
               wb_valid, stall_cnt);
    else passed++;
  endtask

  task automatic test_flags();
    wb_ready = 1'b1;
    drive(1'b1, 16'hFFFF, 4'd7, 1'b0, 3'b101, 1'b1);
    step();
    total++;
    if (flags_reg !== 3'b101 || wb_valid !== 1'b0)
      $display("FAIL flags_load got f=%b v=%b want 101/0",
               flags_reg, wb_valid);
    else passed++;
    drive(1'b1, 16'h0, 4'd0, 1'b0, 3'b010, 1'b0);
    step();
    total++;
    if (flags_reg !== 3'b101)
      $display("FAIL flags_hold got %b want 101", flags_reg);
    else passed++;
    drive(1'b1, 16'h0055, 4'd8, 1'b1, 3'b110, 1'b1);
    step();
    drive(1'b0, 16'h0, 4'd0, 1'b0, 3'b000, 1'b0);
    total++;
    if (flags_reg !== 3'b110 || wb_valid !== 1'b1 ||
        wb_data !== 16'h0055 || wb_rd !== 4'd8)
      $display("FAIL flags_both got f=%b v=%b d=%h want 110/1/0055",
               flags_reg, wb_valid, wb_data);
    else passed++;
    step();
  endtask

  task automatic test_push_pop();
    wb_ready = 1'b0;
    drive(1'b1, 16'h0001, 4'd5, 1'b1, 3'b000, 1'b0);
    step();
    total++;
    if (wb_data !== 16'h0001 || wb_rd !== 4'd5)
      $display("FAIL pp_head got d=%h rd=%0d want 0001/5",
               wb_data, wb_rd);
    else passed++;
    wb_ready = 1'b1;
    drive(1'b1, 16'h0002, 4'd6, 1'b1, 3'b000, 1'b0);
    step();
    drive(1'b0, 16'h0, 4'd0, 1'b0, 3'b000, 1'b0);
    total++;
    if (wb_valid !== 1'b1 || in_ready !== 1'b1 ||
        wb_data !== 16'h0002 || wb_rd !== 4'd6)
      $display("FAIL pp_swap got v=%b rdy=%b d=%h rd=%0d want 1/1/0002/6",
               wb_valid, in_ready, wb_data, wb_rd);
    else passed++;
    step();
    total++;
    if (wb_valid !== 1'b0)
      $display("FAIL pp_drain got %b want 0", wb_valid);
    else passed++;
  endtask

  task automatic test_saturation_reset();
    wb_ready = 1'b0;
    drive(1'b1, 16'h00E1, 4'd1, 1'b1, 3'b000, 1'b0);
    step();
    drive(1'b1, 16'h00E2, 4'd2, 1'b1, 3'b000, 1'b0);
    step();
    drive(1'b1, 16'h00E3, 4'd3, 1'b1, 3'b000, 1'b0);
    for (int i = 0; i < 300; i++) step();
    total++;
    if (stall_cnt !== 8'd255)
      $display("FAIL sat_cnt got %0d want 255", stall_cnt);
    else passed++;
    total++;
    if (wb_valid !== 1'b1 || in_ready !== 1'b0 || wb_data !== 16'h00E1)
      $display("FAIL sat_full got v=%b rdy=%b d=%h want 1/0/00e1",
               wb_valid, in_ready, wb_data);
    else passed++;
    rst = 1'b0;
    #1;
    total++;
    if (stall_cnt !== 8'd0 || in_ready !== 1'b1 || wb_valid !== 1'b0)
      $display("FAIL midrst got s=%0d rdy=%b v=%b want 0/1/0",
               stall_cnt, in_ready, wb_valid);
    else passed++;
    drive(1'b0, 16'h0, 4'd0, 1'b0, 3'b000, 1'b0);
    step();
    rst      = 1'b1;
    wb_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (wb_valid !== 1'b0 || wb_data !== 16'h0)
        $display("FAIL midrst_nowrite%0d got v=%b d=%h want 0/0000",
                 i, wb_valid, wb_data);
      else passed++;
    end
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_single_write();
    test_backpressure();
    test_flags();
    test_push_pop();
    test_saturation_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/nrisc_ula_wb.md
NRISC_ULA_WB -- requirements
Module: nrisc_ula_wb

Interface
REQ-001 SHALL have parameter TAM, default 16: data width, equal to the ULA result width.
REQ-002 SHALL have parameter RA_W, default 4: register-address width.
REQ-003 SHALL have port clk  input  1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port ULA_OUT  input  TAM: ULA result.
REQ-006 SHALL have port ULA_flags  input  3: ULA flags; bit positions preserved end to end.
REQ-007 SHALL have port in_valid  input  1: ULA result/flags/controls valid this cycle.
REQ-008 SHALL have port in_rd  input  RA_W: destination register.
REQ-009 SHALL have port in_rf_we  input  1: result goes to the register file.
REQ-010 SHALL have port in_flag_we  input  1: flags go to the status register.
REQ-011 SHALL have port in_ready  output  1: stage can accept.
REQ-012 SHALL have port wb_valid  output  1: register-file write pending.
REQ-013 SHALL have port wb_data  output  TAM: write data.
REQ-014 SHALL have port wb_rd  output  RA_W: write address.
REQ-015 SHALL have port wb_ready  input  1: register file takes the write this cycle.
REQ-016 SHALL have port flags_reg  output  3: status register.
REQ-017 SHALL have port stall_cnt  output  8: saturating count of stalled cycles.

Function
REQ-018 SHALL define accept as in_valid AND in_ready, and pop as wb_valid AND wb_ready.
REQ-019 SHALL hold writes in a 2-entry FIFO; count ranges 0..2.
REQ-020 SHALL drive in_ready = (count != 2), decoded from registered count only; no combinational path from wb_ready.
REQ-021 SHALL push {ULA_OUT, in_rd} on accept with in_rf_we=1; an accept with in_rf_we=0 SHALL consume the input without pushing.
REQ-022 SHALL drive wb_valid = (count != 0) and show the head entry on wb_data/wb_rd; when empty both SHALL be 0.
REQ-023 SHALL give a write pushed into an empty FIFO a latency of 1 cycle to wb_valid.
REQ-024 SHALL, on simultaneous push and pop at count 1, keep count 1 with the new entry at the head next cycle.
REQ-025 SHALL not push at count 2; a pop at count 2 SHALL raise in_ready the next cycle.
REQ-026 SHALL load ULA_flags into flags_reg at the edge after an accept with in_flag_we=1; otherwise flags_reg holds.
REQ-027 SHALL update flags_reg independently of FIFO occupancy; in_rf_we and in_flag_we may both be 1.
REQ-028 SHALL increment stall_cnt each cycle in_valid=1 AND in_ready=0, saturating at 255.
REQ-029 SHALL advance FIFO pointers modulo 2 with wrap, keeping order.

Reset
REQ-030 SHALL, while rst=0, force count=0, pointers=0, flags_reg=0 and stall_cnt=0, giving in_ready=1, wb_valid=0, wb_data=0 and wb_rd=0.
REQ-031 SHALL discard pending entries on reset mid-operation, with no write issued after rst rises.
REQ-032 SHALL not reset FIFO storage.

Structure
REQ-033 SHALL place TAM, RA_W, flag width 3 and FIFO depth 2 in shared package nrisc_pkg.
REQ-034 SHALL use one sub-module, nrisc_wb_fifo: 2-entry storage, pointers, count, full/empty.
REQ-035 SHALL keep flags register, stall counter and handshake logic in nrisc_ula_wb.

Verification
REQ-036 Reset: rst=0 with in_valid=1 -> in_ready=1, wb_valid=0, flags_reg=0, stall_cnt=0; after rst=1, no spurious write.
REQ-037 Single write: accept ULA_OUT=16'h1234, in_rd=3, in_rf_we=1, wb_ready=1 -> next cycle wb_valid=1, wb_data=16'h1234, wb_rd=3, popped that cycle, then wb_valid=0.
REQ-038 Backpressure: wb_ready=0, three back-to-back accepts 16'hA, 16'hB, 16'hC -> in_ready=0 after the second; stall_cnt=1 per blocked cycle; on wb_ready=1 outputs 16'hA then 16'hB, then 16'hC is accepted.
REQ-039 Flags only: accept ULA_flags=3'b101, in_flag_we=1, in_rf_we=0 -> flags_reg=3'b101 next cycle, wb_valid stays 0; later accept with in_flag_we=0 and ULA_flags=3'b010 -> flags_reg stays 3'b101.
REQ-040 Push+pop at count 1: head 16'h0001, push 16'h0002 with wb_ready=1 -> next cycle count=1, wb_data=16'h0002.
REQ-041 Saturation and mid-op reset: 300 blocked cycles -> stall_cnt=255; rst=0 with count=2 -> count=0, stall_cnt=0, no write after release.
